// File: rtl/switch_pkg.sv
// Shared switch types and destination-code helpers for the crossbar scheduler
// and, later, the egress arbiters.
package switch_pkg;

    localparam int NPORTS_DEF = 4;
    localparam int NPORTS_MAX = 8;

    localparam logic [2:0] PORT_DROP  = 3'b110;
    localparam logic [2:0] PORT_BCAST = 3'b111;

    typedef enum logic {
        SCAN    = 1'b0,
        RESERVE = 1'b1
    } sched_state_t;

    // True when egress 'egress' belongs to the destination set of ingress 'self'.
    // Hairpin, DROP and out-of-range codes never hit any egress.
    function automatic logic dest_hit(input logic [2:0] code, input int self, input int egress);
        if (egress == self)     return 1'b0;
        if (code == PORT_BCAST) return 1'b1;
        if (code == PORT_DROP)  return 1'b0;
        return int'(code) == egress;
    endfunction

    function automatic int oh_to_idx(input logic [NPORTS_MAX-1:0] oh);
        oh_to_idx = 0;
        for (int i = 0; i < NPORTS_MAX; i++) begin
            if (oh[i]) oh_to_idx = i;
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: picks the first request after i_ptr (wrapping),
// so the last winner gets lowest priority next time.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    always_comb begin
        int idx;
        o_grant = '0;
        o_valid = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossbar_scheduler.sv
// Crossbar scheduler: round-robin grant of egress sets to ingress ports, with a
// reservation state so a starved (typically broadcast) request cannot be locked out.
//   state   | meaning
//   SCAN    | round-robin over all eligible ingress ports, one new grant per cycle
//   RESERVE | only r_res_idx may be granted; everyone else keeps waiting
module crossbar_scheduler
    import switch_pkg::*;
#(
    parameter  int NPORTS       = NPORTS_DEF,
    parameter  int STARVE_LIMIT = 16,
    localparam int SW           = $clog2(NPORTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    i_req,
    input  logic [3*NPORTS-1:0]  i_req_dst,
    input  logic [NPORTS-1:0]    i_done,
    output logic [NPORTS-1:0]    o_grant,
    output logic [NPORTS-1:0]    o_out_busy,
    output logic [SW*NPORTS-1:0] o_out_src,
    output logic                 o_reserve_active
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    sched_state_t      r_state;
    logic [NPORTS-1:0] r_grant;
    logic [NPORTS-1:0] r_out_busy;
    logic [SW-1:0]     r_out_src  [NPORTS];
    logic [NPORTS-1:0] r_set_lat  [NPORTS];
    logic [CW-1:0]     r_wait_cnt [NPORTS];
    logic [SW-1:0]     r_rr_ptr;
    logic [SW-1:0]     r_res_idx;
    logic              r_reserve_active;

    logic [NPORTS-1:0] w_set [NPORTS];
    logic [NPORTS-1:0] w_waiting;
    logic [NPORTS-1:0] w_eligible;
    logic [NPORTS-1:0] w_starved;
    logic [NPORTS-1:0] w_scan_oh;
    logic [NPORTS-1:0] w_starve_oh;
    logic [NPORTS-1:0] w_gnt_oh;
    logic              w_scan_vld;
    logic              w_starve_vld;
    logic              w_gnt_vld;
    logic [SW-1:0]     w_gnt_idx;
    logic [SW-1:0]     w_starve_idx;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_ingress
        for (genvar go = 0; go < NPORTS; go++) begin : g_egress
            assign w_set[gi][go] = dest_hit(i_req_dst[3*gi +: 3], gi, go);
        end
        // Eligibility looks only at registered busy flags, so egress ports freed
        // by a done this cycle cannot be reused until the following cycle.
        assign w_waiting[gi]  = i_req[gi] & ~r_grant[gi] & (|w_set[gi]);
        assign w_eligible[gi] = w_waiting[gi] & ~(|(w_set[gi] & r_out_busy));
        assign w_starved[gi]  = w_waiting[gi] & (r_wait_cnt[gi] == LIMIT);
        assign o_out_src[SW*gi +: SW] = r_out_src[gi];
    end

    rr_pick #(.N(NPORTS)) u_pick_grant (
        .i_req   (w_eligible),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_scan_oh),
        .o_valid (w_scan_vld)
    );

    rr_pick #(.N(NPORTS)) u_pick_starve (
        .i_req   (w_starved),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_starve_oh),
        .o_valid (w_starve_vld)
    );

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_oh  = '0;
        if (r_state == SCAN) begin
            w_gnt_vld = w_scan_vld;
            w_gnt_oh  = w_scan_oh;
        end else if (w_eligible[r_res_idx]) begin
            w_gnt_vld            = 1'b1;
            w_gnt_oh[r_res_idx]  = 1'b1;
        end
    end

    assign w_gnt_idx    = SW'(oh_to_idx(NPORTS_MAX'(w_gnt_oh)));
    assign w_starve_idx = SW'(oh_to_idx(NPORTS_MAX'(w_starve_oh)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= SCAN;
            r_grant          <= '0;
            r_out_busy       <= '0;
            r_rr_ptr         <= SW'(NPORTS - 1);
            r_res_idx        <= '0;
            r_reserve_active <= 1'b0;
            for (int i = 0; i < NPORTS; i++) begin
                r_out_src[i]  <= '0;
                r_set_lat[i]  <= '0;
                r_wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (w_waiting[i] && !w_gnt_oh[i])
                    r_wait_cnt[i] <= (r_wait_cnt[i] == LIMIT) ? LIMIT : r_wait_cnt[i] + 1'b1;
                else
                    r_wait_cnt[i] <= '0;

                if (i_done[i] && r_grant[i]) begin
                    r_grant[i] <= 1'b0;
                    for (int o = 0; o < NPORTS; o++) begin
                        if (r_set_lat[i][o]) begin
                            r_out_busy[o] <= 1'b0;
                            r_out_src[o]  <= '0;
                        end
                    end
                end
            end

            // The new grant never overlaps egress ports released above.
            if (w_gnt_vld) begin
                r_grant[w_gnt_idx]   <= 1'b1;
                r_set_lat[w_gnt_idx] <= w_set[w_gnt_idx];
                for (int o = 0; o < NPORTS; o++) begin
                    if (w_set[w_gnt_idx][o]) begin
                        r_out_busy[o] <= 1'b1;
                        r_out_src[o]  <= w_gnt_idx;
                    end
                end
            end

            case (r_state)
                SCAN: begin
                    if (w_gnt_vld) begin
                        r_rr_ptr <= w_gnt_idx;
                    end else if (w_starve_vld) begin
                        r_res_idx        <= w_starve_idx;
                        r_state          <= RESERVE;
                        r_reserve_active <= 1'b1;
                    end
                end
                RESERVE: begin
                    if (!i_req[r_res_idx]) begin
                        r_state          <= SCAN;
                        r_reserve_active <= 1'b0;
                    end else if (w_gnt_vld) begin
                        r_rr_ptr         <= r_res_idx;
                        r_state          <= SCAN;
                        r_reserve_active <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= SCAN;
                    r_reserve_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant          = r_grant;
    assign o_out_busy       = r_out_busy;
    assign o_reserve_active = r_reserve_active;

endmodule

// File: doc/crossbar_scheduler.md
# crossbar_scheduler

Grants the switch crossbar to ingress ports: each ingress port presents a forwarding request (destination code from its frame-forwarding controller) and the scheduler connects it to one egress port, or to all other egress ports for broadcast, until the ingress signals end of frame. Arbitration is round-robin across ingress ports, with a starvation-reservation mode so broadcasts cannot be locked out by unicast traffic. Sits between the per-port receive/trash control and the crossbar mux/egress FIFOs.

## Interface
- NPORTS, 4, number of switch ports (2..8); SW = $clog2(NPORTS)
- STARVE_LIMIT, 16, wait cycles before an ingress port forces a reservation (≥2)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  NPORTS  ingress i has a frame ready to forward; held until grant[i]
- req_dst  in  3*NPORTS  destination code of ingress i, bits [3i+2:3i]; stable while req[i]
- done  in  NPORTS  one-cycle pulse: ingress i finished its frame; ignored unless grant[i]
- grant  out  NPORTS  ingress i owns its destination set
- out_busy  out  NPORTS  egress o is connected to some ingress
- out_src  out  SW*NPORTS  ingress index driving egress o; 0 when idle
- reserve_active  out  1  scheduler is in RESERVE state

## Operation
- Destination set per ingress i: code 0..NPORTS-1 and ≠ i → one-hot of code; 3'b111 (BCAST) → all egress except i; anything else (incl. 3'b110 DROP, hairpin dst == i) → empty. Empty-set requests are never granted and never count as waiting.
- Eligible: req[i]=1, grant[i]=0, set nonempty, every egress in the set has out_busy=0.
- Waiting: req[i]=1, grant[i]=0, set nonempty. wait_cnt[i] increments each waiting cycle, saturates at STARVE_LIMIT, clears when not waiting or on grant.
- States:
  - SCAN: at most one new grant per cycle, to the first eligible ingress scanning rr_ptr+1, rr_ptr+2, … mod NPORTS. On grant to i, rr_ptr ← i. If no grant this cycle and some ingress has wait_cnt = STARVE_LIMIT, res_idx ← first such in the same scan order → RESERVE.
  - RESERVE: only res_idx may be granted (when eligible); others wait. Grant of res_idx → SCAN, rr_ptr ← res_idx. req[res_idx] falling → SCAN, no grant.
- On grant to i: grant[i], out_busy[o] and out_src[o]=i set for every o in the latched set; set latched at grant, req_dst changes afterwards ignored.
- done[i] while grant[i]: grant[i] and every egress in its latched set cleared next edge; out_src returns to 0.
- Independent ingress ports may hold grants concurrently; egress sets of granted ports are always disjoint.
- Reset values: grant 0, out_busy 0, out_src 0, reserve_active 0, state SCAN, rr_ptr NPORTS-1 (ingress 0 first), wait_cnt 0.

## Timing
- Decisions use registered grant/out_busy only; all outputs are registers.
- req seen eligible at cycle t → grant and out_busy/out_src high at t+1.
- done at cycle d → grant low and egress free at d+1; earliest re-grant of those egress ports at d+2 (including same ingress with next frame).
- Simultaneous done on j and new grant on i: both take effect; i cannot use j's egress ports in that cycle.
- done on a non-granted port: no effect. req dropping while granted: no effect, grant held until done.
- Starvation entry: RESERVE entered the edge after wait_cnt reaches STARVE_LIMIT with no grant; worst-case broadcast wait bounded by STARVE_LIMIT + longest in-flight frame + 2 cycles.
- reset mid-frame: all grants and busy flags drop at the reset edge; no partial state retained.

## Structure
- switch_pkg: NPORTS default, PORT_DROP = 3'b110, PORT_BCAST = 3'b111, sched_state_t {SCAN, RESERVE}.
- Sub-module rr_pick: rotating-priority encoder (request vector, pointer → one-hot grant + valid), reused later by egress arbiters.

## Test plan
- Reset, then req[0] dst=2: grant[0] at t+1, out_busy=4'b0100, out_src[2]=0; done[0] → all zero next cycle.
- req[1], req[3] both dst=0 same cycle, rr_ptr=3: ingress 0 idle, grant[1] first; after done[1], grant[3] at done+2.
- req[0] dst=1 and req[2] dst=3 same cycle: grants in consecutive cycles, both held simultaneously, out_src[1]=0, out_src[3]=2.
- req[1] dst=3'b110 and req[2] dst=2: never granted, wait_cnt stays 0, reserve_active stays 0.
- Ingress 0 BCAST while 1,2,3 stream back-to-back unicasts to each other: after 16 waiting cycles reserve_active=1, no new unicast grants, grant[0] with out_busy=4'b1110 once frames finish, then SCAN.
- Assert reset while two grants active: grant=0, out_busy=0, out_src=0 next cycle; req[0] after reset granted first.
